kernel_cc_start_fifo_srl_ext: RTL
=================================

// Module: kernel_cc_start_fifo_srl_ext
// PURPOSE
//  Parametrised shift-register start/control FIFO for kernel_cc dataflow task chaining; next generation of the start_for_* FIFOs.
//  Adds occupancy count, almost-full/almost-empty flags, optional read+write-at-full pass-through, sticky overflow/underflow error flags.
//  Sits between a producer task (ap_start/ap_ready side) and a consumer task; drop-in compatible on the if_* handshake.
// PARAMETERS
//  DATA_WIDTH   1  payload width in bits (>=1)
//  ADDR_WIDTH   2  storage index width; DEPTH <= 2**ADDR_WIDTH
//  DEPTH        4  number of entries (>=2)
//  AF_LEVEL     3  if_almost_full_n=0 when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL     1  if_almost_empty_n=0 when count <= AE_LEVEL (0..DEPTH-1)
//  FULL_PASS    0  1: simultaneous read+write accepted while full
// PORTS
//  clk                 in   1              rising-edge clock
//  reset               in   1              asynchronous, active-high reset
//  if_empty_n          out  1              1 = data available on if_dout
//  if_read_ce          in   1              read clock enable
//  if_read             in   1              read request; pop = if_read & if_read_ce & if_empty_n
//  if_dout             out  DATA_WIDTH     oldest entry (first-word fall-through)
//  if_full_n           out  1              1 = space available
//  if_write_ce         in   1              write clock enable
//  if_write            in   1              write request
//  if_din              in   DATA_WIDTH     write data
//  if_num_data_valid   out  ADDR_WIDTH+1   current occupancy 0..DEPTH
//  if_almost_full_n    out  1              see AF_LEVEL
//  if_almost_empty_n   out  1              see AE_LEVEL
//  err_clr             in   1              synchronous clear of sticky error flags
//  if_overflow         out  1              sticky: write attempted while full and not accepted
//  if_underflow        out  1              sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async assert, sync use after deassert): count=0, if_empty_n=0, if_full_n=1, if_almost_full_n=1, if_almost_empty_n=0,
//    if_overflow=0, if_underflow=0. Storage not reset; if_dout undefined while empty.
//  - wr_req = if_write & if_write_ce; rd_req = if_read & if_read_ce.
//  - push = wr_req & (if_full_n | (FULL_PASS & rd_req)); pop = rd_req & if_empty_n.
//  - Storage: on push, shift SRL[i+1]<=SRL[i], SRL[0]<=if_din. if_dout = SRL[count-1] (combinational from registered count);
//    SRL[0] when count=0.
//  - Count: push&!pop -> +1; pop&!push -> -1; push&pop -> unchanged; otherwise hold.
//  - Flags registered, updated in same cycle as count, all consistent with next count:
//    if_empty_n=(count!=0), if_full_n=(count!=DEPTH),
//    if_almost_full_n=(count<AF_LEVEL), if_almost_empty_n=(count>AE_LEVEL).
//  - Latency: write at edge N -> if_empty_n=1 and data on if_dout after edge N (visible cycle N+1). No combinational path din->dout.
//  - Empty + rd_req + wr_req: write accepted, read ignored (no underflow flagged since push occurs); count 0->1.
//  - Full + rd_req + wr_req: FULL_PASS=0 -> pop only, write dropped, overflow set; FULL_PASS=1 -> both, count stays DEPTH,
//    if_full_n stays 0, new word at tail.
//  - if_overflow set on wr_req & !push; if_underflow set on rd_req & !if_empty_n & !push.
//    Set has priority over err_clr in same cycle.
//  - Reset mid-operation: all contents discarded immediately; first post-reset write behaves as into empty FIFO.
//  - Parameter check: elaboration error if DEPTH>2**ADDR_WIDTH, DEPTH<2, or AF/AE out of range.
// TESTING (DATA_WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless stated)
//  1 Write 0x11,0x22,0x33,0x44 then 4 reads -> dout 0x11..0x44 in order; count 1,2,3,4 then 3..0;
//    full_n=0 only at 4; empty_n=0 at end.
//  2 Almost flags: count 0..4 -> almost_empty_n 0,0,1,1,1; almost_full_n 1,1,1,0,0.
//  3 Empty, simultaneous write 0x5A+read -> count=1, dout=0x5A, underflow=0; read when empty alone -> underflow=1,
//    err_clr -> 0.
//  4 Full (0x01..0x04), read+write 0x05: FULL_PASS=0 -> count=3, overflow=1, dout=0x02;
//    FULL_PASS=1 -> count=4, overflow=0, subsequent reads 0x02,0x03,0x04,0x05.
//  5 Assert reset asynchronously mid-clock with count=3 -> empty_n=0, full_n=1, count=0 before next edge;
//    next write 0x77 read back 0x77.
//  6 Random push/pop 10k cycles vs. reference queue model (both FULL_PASS) -> dout, count, all flags match every cycle.

Source files
------------

// File: rtl/kernel_cc_start_fifo_srl_ext.sv
// Shift-register start/control FIFO with occupancy count, almost flags,
// optional read+write-at-full pass-through and sticky overflow/underflow flags.
module kernel_cc_start_fifo_srl_ext #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3,
  parameter int AE_LEVEL   = 1,
  parameter int FULL_PASS  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n,
  input  logic                  err_clr,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic                PASS_C  = (FULL_PASS != 0);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH) || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
    $error("kernel_cc_start_fifo_srl_ext: illegal DEPTH/ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  af_n_q, af_n_d;
  logic                  ae_n_q, ae_n_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_req, rd_req, push, pop;
  logic [ADDR_WIDTH:0]   cnt_m1;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign wr_req = if_write & if_write_ce;
  assign rd_req = if_read & if_read_ce;
  // At full, a write only gets in when pass-through is enabled and a read frees the head slot.
  assign push   = wr_req & (full_n_q | (PASS_C & rd_req));
  assign pop    = rd_req & empty_n_q;

  // Newest word always lands in slot 0; the oldest sits at slot count-1.
  always_ff @(posedge clk) begin
    if (push) begin
      srl_q[0] <= if_din;
      for (int i = DEPTH - 1; i > 0; i--) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  assign cnt_m1 = count_q - ONE_C;
  assign rd_idx = (count_q == '0) ? '0 : cnt_m1[ADDR_WIDTH-1:0];
  assign if_dout = srl_q[rd_idx];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (pop && !push) begin
      count_d = count_q - ONE_C;
    end
    empty_n_d = (count_d != '0);
    full_n_d  = (count_d != DEPTH_C);
    af_n_d    = (count_d < AF_C);
    ae_n_d    = (count_d > AE_C);
    // A new error event wins over a clear in the same cycle.
    ovf_d     = (ovf_q & ~err_clr) | (wr_req & ~push);
    udf_d     = (udf_q & ~err_clr) | (rd_req & ~empty_n_q & ~push);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_n_q    <= 1'b1;
      ae_n_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_n_q    <= af_n_d;
      ae_n_q    <= ae_n_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign if_empty_n        = empty_n_q;
  assign if_full_n         = full_n_q;
  assign if_num_data_valid = count_q;
  assign if_almost_full_n  = af_n_q;
  assign if_almost_empty_n = ae_n_q;
  assign if_overflow       = ovf_q;
  assign if_underflow      = udf_q;

endmodule
